sbox_loader: RTL and testbench
==============================

SBOX_LOADER -- requirements
Module: sbox_loader

Interface
REQ-001 SHALL have one parameter: SBOX_SIZE, default 256, table depth; only 256 is supported.
REQ-002 SHALL have port clk, input, 1, single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port load_start, input, 1, one-cycle pulse that begins a table load.
REQ-005 SHALL have port in_valid, input, 1, the forward S-box byte is valid.
REQ-006 SHALL have port in_data, input, 8, forward S-box byte, sent in index order 0..255.
REQ-007 SHALL have port in_ready, output, 1, the loader accepts a byte.
REQ-008 SHALL have port sbox_normal, output, 256x8 array, forward table.
REQ-009 SHALL have port sbox_inverse, output, 256x8 array, inverse table.
REQ-010 SHALL have port busy, output, 1, a load is in progress.
REQ-011 SHALL have port tables_valid, output, 1, both tables are complete and form a bijection.
REQ-012 SHALL have port bijective_err, output, 1, the last load contained a duplicate output value.
REQ-013 SHALL have port load_count, output, 9, number of bytes accepted in the current load (0..256).

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, DONE and ERROR.
REQ-015 SHALL define a transfer as a cycle with in_valid && in_ready; in_ready SHALL be 1 only in LOAD.
REQ-016 SHALL, on transfer k (k = load_count), write sbox_normal[k] = in_data, write sbox_inverse[in_data] = k[7:0], set seen[in_data] and increment load_count.
REQ-017 SHALL set a sticky dup flag when a transfer hits an in_data whose seen bit is already set; the inverse entry is still overwritten.
REQ-018 SHALL, on the 256th transfer, go to DONE if dup (including that transfer) is clear, otherwise to ERROR; tables_valid or bijective_err SHALL assert the following cycle.
REQ-019 SHALL, on load_start in any state (including mid-LOAD), enter LOAD next cycle with load_count=0, seen=0, dup=0, tables_valid=0 and bijective_err=0; tables are not cleared.
REQ-020 SHALL give load_start priority if it coincides with a transfer; that transfer is discarded.
REQ-021 SHALL ignore in_valid outside LOAD.
REQ-022 SHALL drive busy = (state == LOAD).
REQ-023 SHALL hold tables_valid high in DONE and bijective_err high in ERROR until the next load_start or rst.
REQ-024 SHALL tolerate gaps in in_valid: no timeout, and LOAD is held indefinitely.
REQ-025 SHALL make table outputs register-driven, with no combinational path from in_data to the table outputs.
REQ-026 SHALL update the tables only from their registered state; consumers SHALL qualify table use with tables_valid.

Reset
REQ-027 SHALL, when rst is high at a clock edge, set state=IDLE, in_ready=0, busy=0, tables_valid=0, bijective_err=0, load_count=0, seen=0, dup=0, and all entries of sbox_normal and sbox_inverse to 8'h00.
REQ-028 SHALL give rst priority over load_start and transfers; reset mid-LOAD SHALL abort the load with no partial-valid indication.

Structure
REQ-029 SHALL place the FSM state typedef, SBOX_SIZE and the table element type (8-bit byte array type) in the shared AES package, which the SubBytes datapath also imports.
REQ-030 SHALL be a single module with no sub-modules; the 256-bit seen vector and the tables are inline registers.

Verification
REQ-031 SHALL cover: full AES forward S-box load -> tables_valid=1 one cycle after the 256th transfer; sbox_inverse[8'h63]=8'h00, sbox_inverse[8'h7C]=8'h01, sbox_inverse[8'hED]=8'h53, sbox_inverse[8'h16]=8'hFF; bijective_err=0.
REQ-032 SHALL cover: identity table load (in_data=k) with in_valid deasserted every third cycle -> sbox_inverse equals sbox_normal, load_count=256, and no bytes lost.
REQ-033 SHALL cover: a load with entry 5 = entry 4 = 8'hAA -> ERROR, bijective_err=1, tables_valid=0, and sbox_inverse[8'hAA]=8'h05.
REQ-034 SHALL cover: load_start after 100 transfers, coinciding with a transfer -> load_count=0 the next cycle, that byte discarded; a subsequent full AES load -> tables_valid=1.
REQ-035 SHALL cover: rst asserted after 50 transfers -> the next cycle shows IDLE, all tables 8'h00, busy=0 and in_ready=0.
REQ-036 SHALL cover: in_valid=1 while in DONE -> no table change, and load_count stays 256.

Source files
------------

// File: rtl/sbox_loader_pkg.sv
// Shared AES types: table depth, byte/table types and the S-box loader FSM states.
// The SubBytes datapath imports this same package to read the loaded tables.
package sbox_loader_pkg;

  localparam int SBOX_SIZE = 256;

  typedef logic [7:0] sbyte_t;
  typedef sbyte_t sbox_tbl_t [SBOX_SIZE];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

endpackage

// File: rtl/sbox_loader.sv
// Streams a forward S-box in index order, building forward and inverse tables
// and flagging whether the loaded table is a bijection.
module sbox_loader
  import sbox_loader_pkg::*;
#(
  parameter int SBOX_SIZE = sbox_loader_pkg::SBOX_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output sbyte_t     sbox_normal  [SBOX_SIZE],
  output sbyte_t     sbox_inverse [SBOX_SIZE],
  output logic       busy,
  output logic       tables_valid,
  output logic       bijective_err,
  output logic [8:0] load_count
);

  state_t               state, state_nxt;
  logic [SBOX_SIZE-1:0] seen;
  logic                 dup;
  logic                 xfer;
  logic                 last;
  logic                 dup_now;

  // load_start wins over a coincident transfer; that byte is dropped.
  assign xfer    = in_valid && (state == LOAD) && !load_start;
  assign last    = (load_count == 9'd255);
  assign dup_now = dup || seen[in_data];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (xfer && last) state_nxt = dup_now ? ERROR : DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    in_ready      = (state == LOAD);
    busy          = (state == LOAD);
    tables_valid  = (state == DONE);
    bijective_err = (state == ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      load_count <= '0;
      seen       <= '0;
      dup        <= 1'b0;
    end else if (xfer) begin
      load_count     <= load_count + 9'd1;
      seen[in_data]  <= 1'b1;
      dup            <= dup_now;
    end
  end

  // Tables are only reset by rst; a new load overwrites them in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SBOX_SIZE; i++) begin
        sbox_normal[i]  <= '0;
        sbox_inverse[i] <= '0;
      end
    end else if (xfer) begin
      sbox_normal[load_count[7:0]] <= in_data;
      sbox_inverse[in_data]        <= load_count[7:0];
    end
  end

endmodule

// File: tb/tb_sbox_loader.sv
module tb_sbox_loader;
  import sbox_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst, load_start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, busy, tables_valid, bijective_err;
  logic [8:0] load_count;
  sbyte_t     sbox_normal  [SBOX_SIZE];
  sbyte_t     sbox_inverse [SBOX_SIZE];

  sbox_loader #(.SBOX_SIZE(256)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .sbox_normal(sbox_normal),
    .sbox_inverse(sbox_inverse), .busy(busy), .tables_valid(tables_valid),
    .bijective_err(bijective_err), .load_count(load_count)
  );

  always #5 clk = ~clk;

  sbyte_t aes [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef enum {K_NORM, K_INV, K_CNT, K_TV, K_BE, K_BUSY, K_RDY, K_ZERO} kind_e;
  typedef struct {
    kind_e kind;
    int    idx;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int probe(exp_t e);
    int n;
    case (e.kind)
      K_NORM: return int'(sbox_normal[e.idx]);
      K_INV:  return int'(sbox_inverse[e.idx]);
      K_CNT:  return int'(load_count);
      K_TV:   return int'(tables_valid);
      K_BE:   return int'(bijective_err);
      K_BUSY: return int'(busy);
      K_RDY:  return int'(in_ready);
      default: begin
        n = 0;
        for (int i = 0; i < 256; i++)
          if (sbox_normal[i] != 8'h00 || sbox_inverse[i] != 8'h00) n++;
        return n;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = probe(e);
      checks++;
      if (act != e.val) begin
        errors++;
        $display("FAIL %s idx=%0d got=%0h want=%0h", e.name, e.idx, act, e.val);
      end
    end
  end

  task automatic push(kind_e k, int idx, int v, string n);
    exp_t e;
    e.kind = k; e.idx = idx; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) begin
      if (sb.size() == 0) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL drain_timeout pending=%0d want=0", sb.size());
    sb.delete();
  endtask

  task automatic start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_checks(string tag);
    push(K_BUSY, 0, 0, {tag, "_busy"});
    push(K_RDY,  0, 0, {tag, "_rdy"});
    push(K_TV,   0, 0, {tag, "_tv"});
    push(K_BE,   0, 0, {tag, "_be"});
    push(K_CNT,  0, 0, {tag, "_cnt"});
    push(K_ZERO, 0, 0, {tag, "_nonzero_entries"});
  endtask

  task automatic aes_load();
    start();
    for (int k = 0; k < 256; k++) send(aes[k]);
  endtask

  task automatic aes_done_checks(string tag);
    push(K_TV,   0, 1, {tag, "_tv"});
    push(K_BE,   0, 0, {tag, "_be"});
    push(K_BUSY, 0, 0, {tag, "_busy"});
    push(K_CNT,  0, 256, {tag, "_cnt"});
    push(K_INV, 8'h63, 8'h00, {tag, "_inv63"});
    push(K_INV, 8'h7c, 8'h01, {tag, "_inv7c"});
    push(K_INV, 8'hed, 8'h53, {tag, "_inved"});
    push(K_INV, 8'h16, 8'hff, {tag, "_inv16"});
  endtask

  sbyte_t dat [256];

  initial begin
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_checks("reset");
    drain();

    start();
    push(K_BUSY, 0, 1, "load_busy");
    push(K_RDY,  0, 1, "load_rdy");
    push(K_CNT,  0, 0, "load_cnt0");
    drain();
    for (int k = 0; k < 256; k++) send(aes[k]);
    checks++;
    if (tables_valid !== 1'b1 || sbox_inverse[8'hed] !== 8'h53) begin
      errors++;
      $display("FAIL direct_aes tv=%0b inved=%0h want=1/53", tables_valid, sbox_inverse[8'hed]);
    end
    aes_done_checks("aes");
    push(K_RDY, 0, 0, "aes_rdy");
    for (int k = 0; k < 256; k++) begin
      push(K_NORM, k, aes[k], "aes_norm");
      push(K_INV, aes[k], k, "aes_inv");
    end
    drain();

    start();
    begin
      int k, cyc;
      k = 0; cyc = 0;
      while (k < 256) begin
        if (cyc % 3 == 2) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end else begin
          send(8'(k));
          k++;
        end
        cyc++;
      end
    end
    push(K_CNT, 0, 256, "ident_cnt");
    push(K_TV,  0, 1, "ident_tv");
    push(K_BE,  0, 0, "ident_be");
    for (int k = 0; k < 256; k++) begin
      push(K_NORM, k, k, "ident_norm");
      push(K_INV,  k, k, "ident_inv");
    end
    drain();

    for (int k = 0; k < 256; k++) dat[k] = 8'(k);
    dat[4] = 8'hAA; dat[5] = 8'hAA; dat[170] = 8'h04;
    start();
    for (int k = 0; k < 10; k++) send(dat[k]);
    push(K_BE,   0, 0, "dup_mid_be");
    push(K_BUSY, 0, 1, "dup_mid_busy");
    push(K_CNT,  0, 10, "dup_mid_cnt");
    drain();
    for (int k = 10; k < 256; k++) send(dat[k]);
    checks++;
    if (bijective_err !== 1'b1 || tables_valid !== 1'b0) begin
      errors++;
      $display("FAIL direct_dup be=%0b tv=%0b want=1/0", bijective_err, tables_valid);
    end
    push(K_BE,  0, 1, "dup_be");
    push(K_TV,  0, 0, "dup_tv");
    push(K_CNT, 0, 256, "dup_cnt");
    push(K_INV, 8'hAA, 8'h05, "dup_invAA");
    push(K_NORM, 5, 8'hAA, "dup_norm5");
    drain();

    start();
    for (int k = 0; k < 100; k++) send(aes[k]);
    load_start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1;
    load_start = 1'b0; in_valid = 1'b0;
    checks++;
    if (load_count !== 9'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL direct_abort cnt=%0d busy=%0b want=0/1", load_count, busy);
    end
    push(K_CNT,  0, 0, "abort_cnt");
    push(K_BUSY, 0, 1, "abort_busy");
    push(K_TV,   0, 0, "abort_tv");
    push(K_BE,   0, 0, "abort_be");
    push(K_NORM, 100, 100, "abort_norm100");
    drain();
    for (int k = 0; k < 256; k++) send(aes[k]);
    aes_done_checks("reload");
    drain();

    start();
    for (int k = 0; k < 50; k++) send(aes[k]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || sbox_normal[0] !== 8'h00) begin
      errors++;
      $display("FAIL direct_rst busy=%0b rdy=%0b norm0=%0h want=0/0/00", busy, in_ready, sbox_normal[0]);
    end
    idle_checks("midrst");
    drain();
    send(8'h11);
    push(K_CNT,  0, 0, "idle_ign_cnt");
    push(K_ZERO, 0, 0, "idle_ign_nonzero");
    drain();

    aes_load();
    aes_done_checks("done");
    drain();
    for (int i = 0; i < 5; i++) send(8'h00);
    push(K_CNT,  0, 256, "done_hold_cnt");
    push(K_TV,   0, 1, "done_hold_tv");
    push(K_NORM, 0, 8'h63, "done_hold_norm0");
    push(K_NORM, 255, 8'h16, "done_hold_norm255");
    push(K_INV,  0, 8'h52, "done_hold_inv0");
    push(K_INV,  8'h63, 8'h00, "done_hold_inv63");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
